// File: rtl/comparador_serial_izq_der.sv
// rtl/comparador_serial_izq_der.sv - MSB-first serial magnitude comparator with start/done handshake
// Scans one bit per clock and stops at the first differing bit.
module comparador_serial_izq_der #(
  parameter int N  = 8,
  parameter int CW = $clog2(N+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  output logic          busy,
  output logic          done,
  output logic          menor_igual,
  output logic          mayor,
  output logic          igual,
  output logic [CW-1:0] bits_evaluados
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] IDX_MSB = IW'(N-1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic          menor_igual_q, menor_igual_d;
  logic          mayor_q, mayor_d;
  logic          igual_q, igual_d;
  logic [CW-1:0] bits_q, bits_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      idx_q         <= '0;
      done_q        <= 1'b0;
      menor_igual_q <= 1'b0;
      mayor_q       <= 1'b0;
      igual_q       <= 1'b0;
      bits_q        <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      idx_q         <= idx_d;
      done_q        <= done_d;
      menor_igual_q <= menor_igual_d;
      mayor_q       <= mayor_d;
      igual_q       <= igual_d;
      bits_q        <= bits_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    idx_d         = idx_q;
    done_d        = 1'b0;
    menor_igual_d = menor_igual_q;
    mayor_d       = mayor_q;
    igual_d       = igual_q;
    bits_d        = bits_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d           = A;
          b_d           = B;
          idx_d         = IDX_MSB;
          menor_igual_d = 1'b0;
          mayor_d       = 1'b0;
          igual_d       = 1'b0;
          bits_d        = '0;
          state_d       = SCAN;
        end
      end
      SCAN: begin
        bits_d = bits_q + CW'(1);
        if (a_q[idx_q] && !b_q[idx_q]) begin
          mayor_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (!a_q[idx_q] && b_q[idx_q]) begin
          menor_igual_d = 1'b1;
          done_d        = 1'b1;
          state_d       = IDLE;
        end else if (idx_q == '0) begin
          // All bits matched down to the LSB.
          igual_d       = 1'b1;
          menor_igual_d = 1'b1;
          done_d        = 1'b1;
          state_d       = IDLE;
        end else begin
          idx_d = idx_q - IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy           = (state_q == SCAN);
  assign done           = done_q;
  assign menor_igual    = menor_igual_q;
  assign mayor          = mayor_q;
  assign igual          = igual_q;
  assign bits_evaluados = bits_q;

endmodule

// File: tb/tb_comparador_serial_izq_der.sv
// tb/tb_comparador_serial_izq_der.sv - randomized self-checking bench for comparador_serial_izq_der
// Reference model: arithmetic compare plus MSB-first position of the first differing bit.
module tb_comparador_serial_izq_der;

  localparam int N  = 8;
  localparam int CW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [N-1:0]  a, b;
  logic          busy, done, menor_igual, mayor, igual;
  logic [CW-1:0] bits_evaluados;

  int checks   = 0;
  int failures = 0;

  comparador_serial_izq_der #(.N(N), .CW(CW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .A              (a),
    .B              (b),
    .busy           (busy),
    .done           (done),
    .menor_igual    (menor_igual),
    .mayor          (mayor),
    .igual          (igual),
    .bits_evaluados (bits_evaluados)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int ref_k(input logic [N-1:0] av, input logic [N-1:0] bv);
    logic [N-1:0] x;
    x = av ^ bv;
    if (x == '0) return N;
    for (int i = N-1; i >= 0; i--)
      if (x[i]) return N - i;
    return N;
  endfunction

  task automatic compare(input logic [N-1:0] av, input logic [N-1:0] bv,
                         input bit noise, input bit gap);
    int k;
    int cyc;
    bit got;
    int exp_mayor, exp_mi, exp_ig;
    k         = ref_k(av, bv);
    exp_mayor = (av > bv)  ? 1 : 0;
    exp_mi    = (av <= bv) ? 1 : 0;
    exp_ig    = (av == bv) ? 1 : 0;

    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("accept_busy", busy, 1);
    check_eq("accept_done", done, 0);
    check_eq("accept_flags", {mayor, menor_igual, igual}, 0);
    check_eq("accept_bits", bits_evaluados, 0);

    got = 0;
    cyc = 0;
    while (!got && cyc < N + 2) begin
      if (noise && busy) begin
        start = 1'b1;
        a = N'($urandom);
        b = N'($urandom);
      end
      tick();
      start = 1'b0;
      cyc++;
      if (done) got = 1;
      else check_eq("scan_flags_zero", {mayor, menor_igual, igual}, 0);
    end

    check_eq("done_seen", got, 1);
    check_eq("latency", cyc, k);
    check_eq("mayor", mayor, exp_mayor);
    check_eq("menor_igual", menor_igual, exp_mi);
    check_eq("igual", igual, exp_ig);
    check_eq("bits_evaluados", bits_evaluados, k);
    check_eq("busy_at_done", busy, 0);

    if (gap) begin
      tick();
      check_eq("done_pulse_end", done, 0);
      check_eq("busy_idle", busy, 0);
      check_eq("held_flags", {mayor, menor_igual, igual}, {exp_mayor[0], exp_mi[0], exp_ig[0]});
      check_eq("held_bits", bits_evaluados, k);
    end
  endtask

  initial begin
    logic [N-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    tick();
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_flags", {mayor, menor_igual, igual}, 0);
    check_eq("rst_bits", bits_evaluados, 0);
    rst_n = 1'b1;

    compare(8'h80, 8'h7F, 0, 1);
    compare(8'h5A, 8'h5A, 0, 1);
    compare(8'h12, 8'h13, 0, 1);
    compare(8'h13, 8'h12, 0, 1);
    compare(8'h0F, 8'h0E, 1, 1);

    // Reset in the middle of a scan abandons it without a done pulse.
    a = 8'h01; b = 8'h01; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_flags", {mayor, menor_igual, igual}, 0);
    check_eq("midrst_bits", bits_evaluados, 0);
    rst_n = 1'b1;
    tick();
    check_eq("postrst_done", done, 0);
    check_eq("postrst_busy", busy, 0);

    compare(8'h40, 8'h80, 0, 0);
    compare(8'h00, 8'h00, 0, 1);

    for (int i = 0; i < 300; i++) begin
      ra = N'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = N'($urandom);
        1:       rb = ra;
        default: rb = ra ^ N'(1 << $urandom_range(0, N-1));
      endcase
      compare(ra, rb, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/comparador_serial_izq_der.md
Name: comparador_serial_izq_der

Overview:
- Sequential magnitude comparator that scans two N-bit unsigned words from left to right (MSB first), one bit per clock.
- It is the counterpart of the combinational right-to-left iterative comparator cell chain.
- Scanning MSB first allows early termination: the first differing bit decides the result, so words that differ high up finish in few cycles.
- Used wherever a registered A<=B / A>B / A==B decision is needed with a start/done handshake.

Parameters:
- N, 8, word width in bits (N >= 2).
- CW, $clog2(N+1), width of the evaluated-bit counter output.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
- start  input  1  request a comparison; accepted only when busy=0.
- A  input  N  first operand, unsigned; sampled only on the accepting edge.
- B  input  N  second operand, unsigned; sampled only on the accepting edge.
- busy  output  1  high while a scan is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- menor_igual  output  1  result: A <= B.
- mayor  output  1  result: A > B.
- igual  output  1  result: A == B.
- bits_evaluados  output  CW  number of bit positions examined in the last comparison (1..N).

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state=IDLE; busy=0, done=0, menor_igual=0, mayor=0, igual=0, bits_evaluados=0; internal regs cleared.
  - Reset has priority over everything, including mid-scan: the scan is abandoned, no done pulse is produced and no result is kept.
- States:
  - IDLE: busy=0.
  - SCAN: busy=1.
- IDLE:
  - start=1 at an edge: latch A and B into internal regs, idx=N-1, clear all three result flags and bits_evaluados, done=0, go to SCAN.
  - start=0: hold. Result flags keep their last values.
- SCAN, each edge compares Areg[idx] vs Breg[idx] and increments bits_evaluados:
  - Areg[idx]=1, Breg[idx]=0: mayor=1, menor_igual=0, igual=0, done=1, go to IDLE.
  - Areg[idx]=0, Breg[idx]=1: menor_igual=1, mayor=0, igual=0, done=1, go to IDLE.
  - Bits equal and idx=0: igual=1, menor_igual=1, mayor=0, done=1, go to IDLE.
  - Bits equal and idx>0: idx=idx-1, stay in SCAN.
- Latency:
  - k = position of the first differing bit counted from the MSB (1-based), or k=N if the words are equal.
  - done and results are visible k cycles after the accepting edge.
  - bits_evaluados=k.
- Output validity:
  - Exactly one of mayor / menor_igual is 1 whenever results are valid.
  - igual=1 implies menor_igual=1.
  - Results stay stable from the done pulse until the next accepted start; they read 0 while busy.
- done:
  - High for exactly one cycle; deasserts on the next edge regardless of start.
- Handshake:
  - start while busy=1 is ignored; it is neither queued nor does it latch operands.
  - Changes to A/B while busy have no effect.
  - start=1 in the same cycle as done=1 (state already IDLE) is accepted: back-to-back throughput is k+1 cycles per comparison.
- Widths:
  - idx is $clog2(N) bits and never wraps; it is not decremented below 0.

Test Plan:
- N=8, rst_n=0 for 2 edges, then start with A=0x80, B=0x7F -> 1 cycle later: done=1, mayor=1, menor_igual=0, igual=0, bits_evaluados=1; next cycle done=0, results held.
- A=0x5A, B=0x5A -> busy=1 for 8 cycles, done 8 cycles after start: igual=1, menor_igual=1, mayor=0, bits_evaluados=8.
- A=0x12, B=0x13 (differ only at LSB) -> done after 8 cycles, menor_igual=1, mayor=0, igual=0; then A=0x13, B=0x12 -> mayor=1.
- start A=0x0F, B=0x0E, then pulse start with A=0xFF, B=0x00 while busy -> the second start is ignored; the result after 8 cycles is mayor=1 for 0x0F vs 0x0E and bits_evaluados=8.
- Start A=0x01, B=0x01, assert rst_n=0 at cycle 3 of the scan -> next edge busy=0, no done pulse, all outputs 0; a new start after reset with A=0x40, B=0x80 -> done after 1 cycle with menor_igual=1.
- Assert start in the done cycle with new operands A=0x00, B=0x00 -> accepted with no idle gap; flags clear, busy=1 on the next edge, igual=1 8 cycles later.
